// File: rtl/md_pkg.sv
// md_pkg
// Shared definitions for the RV32M multiply/divide sequencer.
//   XLEN       : operand/result width (only 32 is supported)
//   md_op_e    : M-extension operation, encoded exactly as funct3
//   md_state_e : sequencer FSM states
//   MD_ITER    : number of radix-2 iterations per operation
//   DIV0_QUOT  : quotient returned for a zero divisor
//   INT_MIN    : most negative 32-bit value, used for the signed overflow case
package md_pkg;

  localparam int XLEN    = 32;
  localparam int MD_ITER = 32;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Operand a is treated as a signed value by these ops.
  function automatic logic op_signed_a(input md_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand b is treated as a signed value by these ops (MULHSU keeps b unsigned).
  function automatic logic op_signed_b(input md_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// md_iter_step
// One combinational radix-2 iteration on the working value {hi, lo}.
//   is_div   : 1 = restoring-division step, 0 = shift-add multiply step
//   hi_in    : 33-bit upper working value (product high half / partial remainder)
//   lo_in    : 32-bit lower working value (multiplier bits / dividend-quotient bits)
//   operand  : multiplicand (multiply) or divisor (divide), already a magnitude
//   hi_out   : upper working value after this iteration
//   lo_out   : lower working value after this iteration
module md_iter_step
  import md_pkg::*;
(
  input  logic        is_div,
  input  logic [32:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic [31:0] operand,
  output logic [32:0] hi_out,
  output logic [31:0] lo_out
);

  logic [32:0] mul_acc;
  logic [32:0] shifted;
  logic [33:0] diff;

  // Multiply: conditionally add the multiplicand into the upper bits, then the
  // whole 65-bit {carry, hi, lo} shifts right so the next multiplier bit reaches lo[0].
  // Divide: the next dividend MSB is shifted into the partial remainder and the
  // divisor is trial-subtracted; a clear borrow bit means the subtraction is kept
  // and a quotient 1 is shifted into lo, otherwise the shifted value is restored.
  always_comb begin
    mul_acc = lo_in[0] ? (hi_in + {1'b0, operand}) : hi_in;
    shifted = {hi_in[31:0], lo_in[31]};
    diff    = {1'b0, shifted} - {2'b00, operand};
    hi_out  = {1'b0, mul_acc[32:1]};
    lo_out  = {mul_acc[0], lo_in[31:1]};
    if (is_div) begin
      if (!diff[33]) begin
        hi_out = diff[32:0];
        lo_out = {lo_in[30:0], 1'b1};
      end else begin
        hi_out = shifted;
        lo_out = {lo_in[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer
// Multi-cycle RV32M multiply/divide unit sitting beside the EX-stage ALU.
//   i_clk        : clock, all state changes on the rising edge
//   i_rst_n      : synchronous active-low reset
//   i_start      : EX holds a valid M-op (only looked at in IDLE)
//   i_md_op      : funct3 of the M-op
//   i_operand_a  : rs1 value
//   i_operand_b  : rs2 value
//   i_flush      : aborts the operation in flight, wins over i_start
//   o_stall      : freezes PC, IF/ID and ID/EX while the unit is working
//   o_busy       : high while iterating
//   o_done       : one-cycle pulse, o_md_data valid in that cycle
//   o_md_data    : registered result, held until the next completion
module md_sequencer
  import md_pkg::*;
#(
  parameter int XLEN = md_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_md_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_md_data
);

  localparam logic [4:0] LAST_ITER = 5'(MD_ITER - 1);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q;
  md_op_e      op_q;
  logic [32:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] opnd_q;
  logic        neg_q;
  logic        neg_rem_q;
  logic [31:0] data_q;

  md_op_e      op_in;
  logic        sa, sb, in_is_div, special;
  logic [31:0] a_mag, b_mag, special_val;

  logic [32:0] step_hi;
  logic [31:0] step_lo;
  logic [63:0] prod, prod_fix;
  logic [31:0] quot_fix, rem_fix, final_res;

  // Incoming operation decode: signs, magnitudes and the two divide cases that
  // skip iteration entirely (zero divisor, and INT_MIN / -1 overflow).
  always_comb begin
    op_in       = md_op_e'(i_md_op);
    in_is_div   = i_md_op[2];
    sa          = op_signed_a(op_in) & i_operand_a[31];
    sb          = op_signed_b(op_in) & i_operand_b[31];
    a_mag       = sa ? (~i_operand_a + 32'd1) : i_operand_a;
    b_mag       = sb ? (~i_operand_b + 32'd1) : i_operand_b;
    special     = 1'b0;
    special_val = 32'd0;
    if (in_is_div) begin
      if (i_operand_b == 32'd0) begin
        special     = 1'b1;
        special_val = i_md_op[1] ? i_operand_a : DIV0_QUOT;
      end else if (op_signed_b(op_in) && (i_operand_a == INT_MIN) &&
                   (i_operand_b == 32'hFFFF_FFFF)) begin
        special     = 1'b1;
        special_val = i_md_op[1] ? 32'd0 : INT_MIN;
      end
    end
  end

  md_iter_step u_step (
    .is_div  (op_q[2]),
    .hi_in   (hi_q),
    .lo_in   (lo_q),
    .operand (opnd_q),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  // Sign fix-up of the value the last iteration produces, so the result register
  // can be loaded on the same edge that enters DONE.
  always_comb begin
    prod      = {step_hi[31:0], step_lo};
    prod_fix  = neg_q ? (~prod + 64'd1) : prod;
    quot_fix  = neg_q ? (~step_lo + 32'd1) : step_lo;
    rem_fix   = neg_rem_q ? (~step_hi[31:0] + 32'd1) : step_hi[31:0];
    final_res = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
    if (op_q[2]) begin
      final_res = op_q[1] ? rem_fix : quot_fix;
    end
  end

  // Next-state logic; a flush always returns to IDLE regardless of state.
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (i_start) state_d = special ? DONE : CALC;
        CALC:    if (cnt_q == LAST_ITER) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Working registers: operands are latched in IDLE, one iteration per CALC
  // cycle, and the result register only changes when an operation completes
  // without being flushed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      op_q      <= OP_MUL;
      hi_q      <= 33'd0;
      lo_q      <= 32'd0;
      opnd_q    <= 32'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      data_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (i_start && !i_flush) begin
            op_q      <= op_in;
            cnt_q     <= 5'd0;
            hi_q      <= 33'd0;
            lo_q      <= in_is_div ? a_mag : b_mag;
            opnd_q    <= in_is_div ? b_mag : a_mag;
            neg_q     <= sa ^ sb;
            neg_rem_q <= sa;
            if (special) data_q <= special_val;
          end
        end
        CALC: begin
          if (!i_flush) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= 5'(cnt_q + 5'd1);
            if (cnt_q == LAST_ITER) data_q <= final_res;
          end
        end
        default: ;
      endcase
    end
  end

  // The stall covers the accepting cycle combinationally and drops in DONE so
  // the EX/MEM register can capture the result.
  always_comb begin
    o_busy    = (state_q == CALC);
    o_stall   = ((state_q == IDLE) && i_start && !i_flush) || (state_q == CALC);
    o_done    = (state_q == DONE) && !i_flush;
    o_md_data = data_q;
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer
// Self-checking bench for md_sequencer: directed cases followed by random
// operations, every result compared with an arithmetic reference model.
module tb_md_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] opa, opb;
  logic        flush;
  logic        stall, busy, done;
  logic [31:0] md_data;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] last_result = 32'd0;

  md_sequencer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_md_op     (md_op),
    .i_operand_a (opa),
    .i_operand_b (opb),
    .i_flush     (flush),
    .o_stall     (stall),
    .o_busy      (busy),
    .o_done      (done),
    .o_md_data   (md_data)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: RV32M results straight from the arithmetic definition
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a64, b64, p;
    logic [31:0] r;
    case (op)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'b001: begin a64 = {{32{a[31]}}, a}; b64 = {{32{b[31]}}, b}; p = a64 * b64; r = p[63:32]; end
      3'b010: begin a64 = {{32{a[31]}}, a}; b64 = {32'd0, b}; p = a64 * b64; r = p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
      $error("[TB] %s miscompare", tag);
    end
  endtask

  // Issue one operation at cycle 0 and follow it to its done pulse
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int exp_cycle;
    int done_cycle;
    logic [31:0] exp_data;
    exp_data  = ref_md(op, a, b);
    exp_cycle = is_special(op, a, b) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; md_op = op; opa = a; opb = b;
    #1 check_output("stall_cycle0", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    done_cycle = 0;
    for (int k = 1; k <= 40 && done_cycle == 0; k++) begin
      if (done) begin
        done_cycle = k;
      end else begin
        if (k < exp_cycle) check_output("stall_calc", {30'd0, stall, busy}, 32'd3);
        @(posedge clk); #1;
      end
    end
    check_output("done_cycle", done_cycle, exp_cycle);
    check_output($sformatf("result_op%0d", op), md_data, exp_data);
    check_output("stall_in_done", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check_output("done_pulse_width", {31'd0, done}, 32'd0);
    check_output("result_hold", md_data, exp_data);
    last_result = exp_data;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          sel;
    int          seen_done;

    rst_n = 1'b0; start = 1'b0; md_op = 3'd0; opa = 32'd0; opb = 32'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_outputs", {29'd0, stall, busy, done}, 32'd0);
    check_output("reset_data", md_data, 32'd0);
    rst_n = 1'b1;

    // Directed multiply cases
    apply_stimulus(3'b000, 32'd7, 32'hFFFF_FFFD);
    apply_stimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    apply_stimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    apply_stimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Directed divide cases
    apply_stimulus(3'b100, 32'hFFFF_FFF9, 32'd2);
    apply_stimulus(3'b110, 32'hFFFF_FFF9, 32'd2);
    apply_stimulus(3'b101, 32'd100, 32'd7);
    apply_stimulus(3'b111, 32'd100, 32'd7);

    // Special cases resolved without iterating
    apply_stimulus(3'b101, 32'd5, 32'd0);
    apply_stimulus(3'b111, 32'd5, 32'd0);
    apply_stimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    apply_stimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in cycle 10 of a divide
    apply_stimulus(3'b101, 32'd77, 32'd5);
    @(negedge clk);
    start = 1'b1; md_op = 3'b100; opa = 32'd1000; opb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check_output("busy_before_flush", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    #1 check_output("done_during_flush", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check_output("flush_outputs", {29'd0, stall, busy, done}, 32'd0);
    check_output("flush_data_kept", md_data, last_result);
    seen_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check_output("no_done_after_flush", seen_done, 0);
    apply_stimulus(3'b000, 32'd3, 32'd4);

    // Reset in cycle 15 of a multiply
    @(negedge clk);
    start = 1'b1; md_op = 3'b000; opa = 32'h1234_5678; opb = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_output("midop_reset_outputs", {29'd0, stall, busy, done}, 32'd0);
    check_output("midop_reset_data", md_data, 32'd0);
    rst_n = 1'b1;
    apply_stimulus(3'b101, 32'd9, 32'd3);

    // Random operations, biased towards boundary operands now and then
    for (int n = 0; n < 24; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) ra = 32'h8000_0000;
      apply_stimulus(rop, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
